// File: rtl/telem_update_arbiter.sv
// Round-robin write-side arbiter for the 16-target telemetry register file.
// Each granted update is checked against its target's stored time before it is written.
module telem_update_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 8,
    parameter int TGT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*TGT_W-1:0]   req_target,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*COORD_W-1:0] req_z,
    input  logic [NUM_REQ*COORD_W-1:0] req_t,
    output logic                       wr_en,
    output logic [TGT_W-1:0]           wr_target,
    output logic [COORD_W-1:0]         wr_x,
    output logic [COORD_W-1:0]         wr_y,
    output logic [COORD_W-1:0]         wr_z,
    output logic [COORD_W-1:0]         wr_t,
    output logic                       drop_pulse,
    output logic [7:0]                 drop_count,
    output logic [15:0]                target_live
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_TGT = 16;

    typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;
    logic               grant_found;
    logic               accept;
    logic [COORD_W-1:0] delta;

    logic [TGT_W-1:0]   hold_target;
    logic [COORD_W-1:0] hold_x;
    logic [COORD_W-1:0] hold_y;
    logic [COORD_W-1:0] hold_z;
    logic [COORD_W-1:0] hold_t;
    logic [COORD_W-1:0] last_t [NUM_TGT];

    // First valid channel at or above rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                winner      = cand;
            end
        end
        rr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

    // Wrap-aware freshness: a live target only takes strictly newer times within half the range.
    always_comb begin
        delta  = hold_t - last_t[hold_target];
        accept = !target_live[hold_target] || ((delta != '0) && !delta[COORD_W-1]);
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        wr_en      = 1'b0;
        wr_target  = '0;
        wr_x       = '0;
        wr_y       = '0;
        wr_z       = '0;
        wr_t       = '0;
        drop_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[winner] = !rst;
                    state_next        = CHECK;
                end
            end
            CHECK: begin
                state_next = accept ? WRITE : IDLE;
                drop_pulse = !accept && !rst;
            end
            WRITE: begin
                state_next = IDLE;
                if (!rst) begin
                    wr_en     = 1'b1;
                    wr_target = hold_target;
                    wr_x      = hold_x;
                    wr_y      = hold_y;
                    wr_z      = hold_z;
                    wr_t      = hold_t;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            target_live <= '0;
            drop_count  <= '0;
            hold_target <= '0;
            hold_x      <= '0;
            hold_y      <= '0;
            hold_z      <= '0;
            hold_t      <= '0;
            for (int i = 0; i < NUM_TGT; i++) begin
                last_t[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && grant_found) begin
                hold_target <= req_target[int'(winner)*TGT_W +: TGT_W];
                hold_x      <= req_x[int'(winner)*COORD_W +: COORD_W];
                hold_y      <= req_y[int'(winner)*COORD_W +: COORD_W];
                hold_z      <= req_z[int'(winner)*COORD_W +: COORD_W];
                hold_t      <= req_t[int'(winner)*COORD_W +: COORD_W];
                rr_ptr      <= rr_next;
            end
            if (state == CHECK && !accept && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (state == WRITE) begin
                last_t[hold_target]      <= hold_t;
                target_live[hold_target] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_telem_update_arbiter.sv
// Bench for telem_update_arbiter: an event-scheduling reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_telem_update_arbiter;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_target = '0;
    logic [31:0] req_x = '0, req_y = '0, req_z = '0, req_t = '0;
    logic        wr_en;
    logic [3:0]  wr_target;
    logic [7:0]  wr_x, wr_y, wr_z, wr_t;
    logic        drop_pulse;
    logic [7:0]  drop_count;
    logic [15:0] target_live;

    int total = 0;
    int bad   = 0;

    // reference model: a grant decides its outcome at once and schedules the visible effects
    int          cyc;
    int          busy_until;
    int          rr_m;
    int          wr_cyc;
    int          drop_cyc;
    logic [3:0]  m_tgt;
    logic [7:0]  m_x, m_y, m_z, m_t;
    int          m_last [16];
    bit          m_live [16];
    int          vis_count;
    logic [15:0] vis_live;
    int          drops_seen = 0;
    logic [3:0]  seen_wr_target = '0;
    logic [7:0]  seen_wr_x = '0;
    logic [7:0]  seen_wr_t = '0;

    telem_update_arbiter #(.NUM_REQ(4), .COORD_W(8), .TGT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_t(req_t),
        .wr_en(wr_en), .wr_target(wr_target),
        .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_t(wr_t),
        .drop_pulse(drop_pulse), .drop_count(drop_count), .target_live(target_live)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_last[i] = 0;
            m_live[i] = 1'b0;
        end
        vis_count  = 0;
        vis_live   = '0;
        wr_cyc     = -1;
        drop_cyc   = -1;
        rr_m       = 0;
        busy_until = cyc + 1;
    endtask

    // compare process: every negedge, DUT outputs against the model
    initial begin : compare_proc
        logic [3:0] exp_ready;
        int         win;
        bit         exp_wr;
        bit         exp_drop;
        logic [3:0] g_tgt;
        logic [7:0] g_t;
        int         d;
        cyc = 0;
        modelReset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ready = '0;
            win = -1;
            if (!rst && cyc >= busy_until) begin
                for (int k = 0; k < NR; k++) begin
                    if (win < 0 && req_valid[(rr_m + k) % NR]) win = (rr_m + k) % NR;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            exp_wr   = !rst && (cyc == wr_cyc);
            exp_drop = !rst && (cyc == drop_cyc);

            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("wr_en", wr_en, exp_wr);
            checkOutput("wr_target", wr_target, exp_wr ? m_tgt : 4'h0);
            checkOutput("wr_x", wr_x, exp_wr ? m_x : 8'h0);
            checkOutput("wr_y", wr_y, exp_wr ? m_y : 8'h0);
            checkOutput("wr_z", wr_z, exp_wr ? m_z : 8'h0);
            checkOutput("wr_t", wr_t, exp_wr ? m_t : 8'h0);
            checkOutput("drop_pulse", drop_pulse, exp_drop);
            checkOutput("drop_count", drop_count, vis_count);
            checkOutput("target_live", target_live, vis_live);

            if (drop_pulse === 1'b1) drops_seen++;
            if (wr_en === 1'b1) begin
                seen_wr_target = wr_target;
                seen_wr_x      = wr_x;
                seen_wr_t      = wr_t;
            end

            if (rst) begin
                modelReset();
            end else begin
                if (exp_wr) vis_live[m_tgt] = 1'b1;
                if (exp_drop) vis_count = (vis_count < 255) ? vis_count + 1 : 255;
                if (win >= 0) begin
                    g_tgt = req_target[win*4 +: 4];
                    g_t   = req_t[win*8 +: 8];
                    d     = (int'(g_t) - m_last[g_tgt] + 256) % 256;
                    if (!m_live[g_tgt] || (d >= 1 && d <= 127)) begin
                        m_tgt = g_tgt;
                        m_x   = req_x[win*8 +: 8];
                        m_y   = req_y[win*8 +: 8];
                        m_z   = req_z[win*8 +: 8];
                        m_t   = g_t;
                        m_last[g_tgt] = int'(g_t);
                        m_live[g_tgt] = 1'b1;
                        wr_cyc     = cyc + 2;
                        busy_until = cyc + 3;
                    end else begin
                        drop_cyc   = cyc + 1;
                        busy_until = cyc + 2;
                    end
                    rr_m = (win + 1) % NR;
                end
            end
            cyc++;
        end
    end

    task automatic setFields(input int ch, input logic [3:0] tgt,
                             input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] z, input logic [7:0] t);
        req_target[ch*4 +: 4] = tgt;
        req_x[ch*8 +: 8] = x;
        req_y[ch*8 +: 8] = y;
        req_z[ch*8 +: 8] = z;
        req_t[ch*8 +: 8] = t;
    endtask

    // hold one channel's request until it is accepted, then drop valid
    task automatic applyStimulus(input int ch, input logic [3:0] tgt,
                                 input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] z, input logic [7:0] t);
        bit got = 1'b0;
        setFields(ch, tgt, x, y, z, t);
        req_valid[ch] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[ch] === 1'b1) got = 1'b1;
        end
        checkOutput("handshake", got, 1'b1);
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int order [5];
        int grants;
        int drops_start;
        bit got;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single request straight after reset
        applyStimulus(0, 4'd3, 8'h55, 8'hF0, 8'hAA, 8'h10);
        waitCycles(3);
        checkOutput("single_live", target_live, 16'h0008);
        checkOutput("single_wr_target", seen_wr_target, 4'd3);
        checkOutput("single_wr_x", seen_wr_x, 8'h55);

        // round robin with every channel held valid
        resetDut();
        for (int i = 0; i < 4; i++) setFields(i, 4'(i), 8'(i), 8'(i + 8), 8'(i + 16), 8'h01);
        req_valid = 4'hF;
        grants = 0;
        for (int i = 0; i < 60 && grants < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (req_ready[k] === 1'b1 && grants < 5) begin
                    order[grants] = k;
                    grants++;
                end
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        checkOutput("rr_grants", grants, 5);
        checkOutput("rr_order0", order[0], 0);
        checkOutput("rr_order1", order[1], 1);
        checkOutput("rr_order2", order[2], 2);
        checkOutput("rr_order3", order[3], 3);
        checkOutput("rr_order4", order[4], 0);
        waitCycles(3);
        checkOutput("rr_live", target_live, 16'h000F);
        checkOutput("rr_dup_count", drop_count, 8'd1);

        // time checks on target 11
        resetDut();
        applyStimulus(2, 4'd11, 8'h01, 8'h02, 8'h03, 8'h20);
        applyStimulus(2, 4'd11, 8'h01, 8'h02, 8'h03, 8'h20);
        applyStimulus(2, 4'd11, 8'h01, 8'h02, 8'h03, 8'h1F);
        applyStimulus(2, 4'd11, 8'h01, 8'h02, 8'h03, 8'hA0);
        applyStimulus(2, 4'd11, 8'h01, 8'h02, 8'h03, 8'h9F);
        waitCycles(4);
        checkOutput("time_drop_count", drop_count, 8'd3);
        checkOutput("time_live", target_live, 16'h0800);
        checkOutput("time_last_wr_t", seen_wr_t, 8'h9F);

        // time wrap on target 5
        applyStimulus(1, 4'd5, 8'h11, 8'h22, 8'h33, 8'hFE);
        applyStimulus(3, 4'd5, 8'h44, 8'h55, 8'h66, 8'h01);
        waitCycles(4);
        checkOutput("wrap_wr_t", seen_wr_t, 8'h01);
        checkOutput("wrap_wr_target", seen_wr_target, 4'd5);
        checkOutput("wrap_live", target_live, 16'h0820);

        // reset during CHECK of an acceptable update
        setFields(1, 4'd7, 8'h77, 8'h78, 8'h79, 8'h33);
        req_valid[1] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1] === 1'b1) got = 1'b1;
        end
        checkOutput("midrst_handshake", got, 1'b1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_live", target_live, 16'h0000);
        checkOutput("midrst_count", drop_count, 8'd0);
        checkOutput("midrst_wr_en", wr_en, 1'b0);
        @(posedge clk);
        #1;
        setFields(0, 4'd1, 8'h01, 8'h01, 8'h01, 8'h05);
        setFields(3, 4'd2, 8'h02, 8'h02, 8'h02, 8'h06);
        req_valid = 4'b1001;
        @(negedge clk);
        checkOutput("midrst_first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        applyStimulus(3, 4'd2, 8'h02, 8'h02, 8'h02, 8'h06);
        waitCycles(4);

        // drop counter saturation
        resetDut();
        applyStimulus(0, 4'd9, 8'h90, 8'h91, 8'h92, 8'h40);
        drops_start = drops_seen;
        repeat (260) applyStimulus(0, 4'd9, 8'h90, 8'h91, 8'h92, 8'h40);
        waitCycles(3);
        checkOutput("sat_drop_count", drop_count, 8'd255);
        checkOutput("sat_drop_pulses", drops_seen - drops_start, 260);

        waitCycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/telem_update_arbiter.md
# telem_update_arbiter

Write-side controller for the 16-target telemetry register file. It arbitrates target-update requests from NUM_REQ sensor channels with a round-robin policy. Each request is checked against the last time coordinate stored for its target, and stale or duplicate updates are dropped. Accepted updates are issued as a single-cycle write strobe, with target select and X/Y/Z/T coordinates, to the target register file. It also maintains a live map of which targets hold valid data.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting sensor channels (2..8)
- COORD_W, 8, width of each coordinate and of the time field
- TGT_W, 4, target-select width (16 targets)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-channel request valid
- req_ready  out  NUM_REQ  per-channel accept; transfer occurs when valid & ready
- req_target  in  NUM_REQ*TGT_W  packed target index; channel i at [i*TGT_W +: TGT_W]
- req_x, req_y, req_z, req_t  in  NUM_REQ*COORD_W each  packed coordinates, same packing
- wr_en  out  1  register-file write strobe, one cycle per accepted update
- wr_target  out  TGT_W  target index for the write
- wr_x, wr_y, wr_z, wr_t  out  COORD_W each  coordinates for the write
- drop_pulse  out  1  one-cycle pulse when an update is rejected
- drop_count  out  8  count of rejected updates, saturating at 255
- target_live  out  16  bit k set once target k has been written since reset

## Operation
- FSM states: IDLE, CHECK, WRITE.
- IDLE:
  - If any req_valid is high, grant the first valid channel searching upward from rr_ptr (wrapping modulo NUM_REQ).
  - req_ready[winner] = 1 this cycle only. req_ready is combinational from req_valid and rr_ptr, and is 0 outside IDLE.
  - Latch the winner's target and coordinates into holding registers.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Next state CHECK.
- CHECK: compute d = (latched_t - last_t[target]) mod 2^COORD_W.
  - Accept if target_live[target] = 0.
  - Otherwise accept if 1 ≤ d ≤ 2^(COORD_W-1) - 1 (newer, wrap-aware).
  - Otherwise reject: d = 0 is a duplicate; d ≥ 128 is stale.
  - Accept: next state WRITE.
  - Reject: drop_pulse = 1, drop_count increments unless already 255, next state IDLE.
- WRITE:
  - wr_en = 1 and wr_* = latched fields.
  - last_t[target] <= latched_t.
  - target_live[target] <= 1.
  - Next state IDLE.
- Internal state: last_t is a 16 x COORD_W array, written only in WRITE.
- Requesters hold req_valid and all fields stable until they see req_ready. Dropping valid without a handshake is permitted and has no effect.
- Outside WRITE, wr_en = 0 and wr_* hold 0.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, target_live=0, last_t all 0, drop_count=0.
  - wr_en=0, wr_*=0, drop_pulse=0, req_ready=0 while rst is high.
- Latency from handshake cycle N:
  - Accepted update: wr_en in cycle N+2.
  - Rejected update: drop_pulse in cycle N+1.
- Throughput:
  - Accepted updates: at most one per 3 cycles.
  - Rejected updates: one per 2 cycles. The next grant can occur in cycle N+2 after a reject, or N+3 after an accept.
- Same target back-to-back: the second request's CHECK sees the last_t written by the first request's WRITE.
- Reset mid-operation: rst in CHECK or WRITE aborts the update. No wr_en or drop_pulse is issued for it, and the granted request is lost (requester must resend).
- Simultaneous valids are resolved by rr_ptr only. No channel waits more than NUM_REQ grants.
- drop_count at 255 stays 255. drop_pulse still fires.

## Test plan
- Reset then single request: ch0 valid, target 3, X=0x55 Y=0xF0 Z=0xAA T=0x10.
  - req_ready[0] in cycle N.
  - wr_en in N+2 with wr_target=3 and the same fields.
  - target_live=0x0008.
- Round robin: all 4 channels valid continuously, distinct targets 0..3, T=0x01.
  - Grant order 0,1,2,3,0.
  - wr_en every 3rd cycle.
  - target_live=0x000F after four writes.
- Time check on target 11, in sequence:
  - T=0x20 is accepted.
  - T=0x20 again is dropped (drop_pulse, drop_count=1).
  - T=0x1F is dropped (count=2).
  - T=0xA0 (d=128) is dropped (count=3).
  - T=0x9F is accepted.
- Wrap: target 5 at T=0xFE, then T=0x01 (d=3).
  - Second update is accepted, and wr_t=0x01.
- Reset mid-operation: assert rst in the CHECK cycle of an accepted-eligible request.
  - No wr_en follows.
  - All outputs and target_live are 0 on the next cycle.
  - The next grant goes to ch0 first.
- Saturation: 260 duplicate updates to a live target.
  - drop_count ends at 255.
  - drop_pulse on every reject.
